ula_control: RTL and testbench

- Decode/issue stage that produces the 4-bit ULA operation select and both ULA operands from RV32I instruction fields.
- Drives the select_ula/data1_in/data2_in side of the ULA from a registered, valid/ready-handshaked output.
- Sits between ID and EX.
- Contains a 2-entry skid buffer, so back-pressure from EX never drops an instruction and throughput stays at 1 instruction per cycle.

---
 rtl/ula_control.sv | 213 +++++++++++++++++++++
 tb/tb_ula_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_control.sv
// Decodes RV32I fields into a ULA select plus two operands, buffered in a 2-entry skid FIFO.
// Latency: accepted on edge N, visible on the outputs right after edge N, consumable at edge N+1.
// Backpressure: in_ready (registered) drops when both entries are full; no entry is ever dropped.
//
// Ports:
//   clk, rst_n (async active-low), flush (synchronous kill of all buffered entries)
//   in_valid/in_ready      : upstream handshake carrying opcode, funct3, funct7, rs1_data, rs2_data, imm, pc
//   out_valid/out_ready    : downstream handshake carrying select_ula, data1_out, data2_out, illegal
//   illegal_count          : present only when ULA_CTRL_STATS_EN is defined; saturating count of emitted illegal entries
module ula_control #(
    parameter int XLEN        = 32,
    parameter int LINK_OFFSET = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      select_ula,
    output logic [XLEN-1:0] data1_out,
    output logic [XLEN-1:0] data2_out,
    output logic            illegal
`ifdef ULA_CTRL_STATS_EN
    ,
    output logic [15:0]     illegal_count
`endif
);

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b0001;
    localparam logic [3:0] SEL_SUB  = 4'b0010;
    localparam logic [3:0] SEL_SLL  = 4'b0011;
    localparam logic [3:0] SEL_SLT  = 4'b0100;
    localparam logic [3:0] SEL_SLTU = 4'b0101;
    localparam logic [3:0] SEL_SRL  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_XOR  = 4'b1000;
    localparam logic [3:0] SEL_OR   = 4'b1001;
    localparam logic [3:0] SEL_AND  = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]      sel;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            ill;
    } entry_t;

    entry_t          slot0, slot1, slot0_nxt, slot1_nxt, dec;
    logic [1:0]      count, count_nxt;
    logic            in_ready_q;
    logic            accept, emit;
    logic            is_op, f7_zero, f7_alt, shift, bad;
    logic [3:0]      sel;
    logic [XLEN-1:0] src1, src2;

    assign is_op   = (opcode == OPC_OP);
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    // Decode
    always_comb begin
        sel   = SEL_NONE;
        src1  = '0;
        src2  = '0;
        shift = 1'b0;
        bad   = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                src1 = rs1_data;
                src2 = is_op ? rs2_data : imm;
                case (funct3)
                    3'b000: begin
                        // OP-IMM has no SUB form: ADDI ignores the upper immediate bits
                        if (!is_op || f7_zero) sel = SEL_ADD;
                        else if (f7_alt)       sel = SEL_SUB;
                        else                   bad = 1'b1;
                    end
                    3'b001: begin
                        sel   = SEL_SLL;
                        shift = 1'b1;
                        bad   = !f7_zero;
                    end
                    3'b101: begin
                        shift = 1'b1;
                        if (f7_zero)     sel = SEL_SRL;
                        else if (f7_alt) sel = SEL_SRA;
                        else             bad = 1'b1;
                    end
                    default: begin
                        case (funct3)
                            3'b010:  sel = SEL_SLT;
                            3'b011:  sel = SEL_SLTU;
                            3'b100:  sel = SEL_XOR;
                            3'b110:  sel = SEL_OR;
                            default: sel = SEL_AND;
                        endcase
                        // immediate forms carry immediate bits in funct7, so only OP checks it
                        bad = is_op && !f7_zero;
                    end
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                sel  = SEL_ADD;
                src1 = rs1_data;
                src2 = imm;
            end
            OPC_BRANCH: begin
                src1 = rs1_data;
                src2 = rs2_data;
                case (funct3)
                    3'b000, 3'b001: sel = SEL_SUB;
                    3'b100, 3'b101: sel = SEL_SLT;
                    3'b110, 3'b111: sel = SEL_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                sel  = SEL_ADD;
                src2 = imm;
            end
            OPC_AUIPC: begin
                sel  = SEL_ADD;
                src1 = pc;
                src2 = imm;
            end
            OPC_JAL, OPC_JALR: begin
                sel  = SEL_ADD;
                src1 = pc;
                src2 = XLEN'(LINK_OFFSET);
                bad  = (opcode == OPC_JALR) && (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase

        dec.sel = sel;
        dec.d1  = src1;
        dec.d2  = shift ? {{(XLEN-5){1'b0}}, src2[4:0]} : src2;
        dec.ill = bad;
        if (bad) begin
            dec.sel = SEL_NONE;
            dec.d1  = '0;
            dec.d2  = '0;
        end
    end

    // flush overrides both handshakes
    assign accept = in_valid && in_ready_q && !flush;
    assign emit   = out_valid && out_ready && !flush;

    // Skid FIFO next state: head shifts on emit, new entry lands in the first free slot
    always_comb begin
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        if (emit) slot0_nxt = slot1;
        if (accept) begin
            if (count == 2'd0 || (count == 2'd1 && emit)) slot0_nxt = dec;
            else                                          slot1_nxt = dec;
        end
        count_nxt = count + {1'b0, accept} - {1'b0, emit};
        if (flush) count_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0      <= '0;
            slot1      <= '0;
            count      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            slot0      <= slot0_nxt;
            slot1      <= slot1_nxt;
            count      <= count_nxt;
            in_ready_q <= (count_nxt != 2'd2);
        end
    end

`ifdef ULA_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (emit && slot0.ill && illegal_count != 16'hFFFF) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = (count != 2'd0);
    assign select_ula = slot0.sel;
    assign data1_out  = slot0.d1;
    assign data2_out  = slot0.d2;
    assign illegal    = slot0.ill;

endmodule

// File: tb/tb_ula_control.sv
module tb_ula_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  select_ula;
    logic [31:0] data1_out, data2_out;
    logic        illegal;
`ifdef ULA_CTRL_STATS_EN
    logic [15:0] illegal_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ula_control #(.XLEN(32), .LINK_OFFSET(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .select_ula(select_ula), .data1_out(data1_out), .data2_out(data2_out),
        .illegal(illegal)
`ifdef ULA_CTRL_STATS_EN
        , .illegal_count(illegal_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [31:0] p);
        in_valid = 1'b1;
        opcode = op; funct3 = f3; funct7 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; pc = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        #2;
        tests++;
        if ({out_valid, in_ready, select_ula, data1_out, data2_out, illegal} !== 71'd0) begin
            fails++;
            $display("FAIL reset_outputs: got ov=%b ir=%b sel=%b d1=%h d2=%h ill=%b, want all 0",
                     out_valid, in_ready, select_ula, data1_out, data2_out, illegal);
        end
        #1 rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready_rise: got %b want 1", in_ready);
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        present(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd3, 32'hDEAD, 32'h0);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, select_ula, data1_out, data2_out, illegal} !== {1'b1, 4'b0010, 32'd5, 32'd3, 1'b0}) begin
            fails++;
            $display("FAIL sub: got ov=%b sel=%b d1=%h d2=%h ill=%b want 1 0010 5 3 0",
                     out_valid, select_ula, data1_out, data2_out, illegal);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL sub_consumed: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_sra_imm();
        present(7'b0010011, 3'b101, 7'b0100000, 32'h80000000, 32'h12345678, 32'hFFFFFFE3, 32'h0);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({select_ula, data1_out, data2_out} !== {4'b0111, 32'h80000000, 32'h00000003}) begin
            fails++;
            $display("FAIL srai: got sel=%b d1=%h d2=%h want 0111 80000000 00000003",
                     select_ula, data1_out, data2_out);
        end
        // SLL register form masks rs2 to its low 5 bits
        present(7'b0110011, 3'b001, 7'b0000000, 32'h1, 32'hFFFFFF25, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({select_ula, data2_out} !== {4'b0011, 32'h00000005}) begin
            fails++;
            $display("FAIL sll_mask: got sel=%b d2=%h want 0011 00000005", select_ula, data2_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        present(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'h0, 32'h0);
        tick();
        present(7'b0110011, 3'b100, 7'b0000000, 32'd3, 32'd4, 32'h0, 32'h0);
        tick();
        tests++;
        if ({in_ready, out_valid, select_ula} !== {1'b0, 1'b1, 4'b0001}) begin
            fails++;
            $display("FAIL b2b_full: got ir=%b ov=%b sel=%b want 0 1 0001", in_ready, out_valid, select_ula);
        end
        present(7'b0110011, 3'b111, 7'b0000000, 32'd5, 32'd6, 32'h0, 32'h0);
        tick();
        tests++;
        if ({in_ready, select_ula, data1_out} !== {1'b0, 4'b0001, 32'd1}) begin
            fails++;
            $display("FAIL b2b_stall_stable: got ir=%b sel=%b d1=%h want 0 0001 1", in_ready, select_ula, data1_out);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({in_ready, select_ula, data1_out} !== {1'b1, 4'b1000, 32'd3}) begin
            fails++;
            $display("FAIL b2b_second: got ir=%b sel=%b d1=%h want 1 1000 3", in_ready, select_ula, data1_out);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, select_ula, data1_out, data2_out} !== {1'b1, 4'b1010, 32'd5, 32'd6}) begin
            fails++;
            $display("FAIL b2b_third: got ov=%b sel=%b d1=%h d2=%h want 1 1010 5 6",
                     out_valid, select_ula, data1_out, data2_out);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drained: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_auipc_jal();
        out_ready = 1'b1;
        present(7'b0010111, 3'b000, 7'b0000000, 32'h55, 32'h66, 32'h2000, 32'h100);
        tick();
        tests++;
        if ({select_ula, data1_out, data2_out} !== {4'b0001, 32'h100, 32'h2000}) begin
            fails++;
            $display("FAIL auipc: got sel=%b d1=%h d2=%h want 0001 100 2000", select_ula, data1_out, data2_out);
        end
        present(7'b1101111, 3'b000, 7'b0000000, 32'h55, 32'h66, 32'h2000, 32'h100);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, select_ula, data1_out, data2_out} !== {1'b1, 4'b0001, 32'h100, 32'h4}) begin
            fails++;
            $display("FAIL jal: got ov=%b sel=%b d1=%h d2=%h want 1 0001 100 4",
                     out_valid, select_ula, data1_out, data2_out);
        end
        tick();
    endtask

    task automatic test_branch_lui();
        out_ready = 1'b1;
        present(7'b1100011, 3'b110, 7'b0000000, 32'h7, 32'h9, 32'h40, 32'h0);
        tick();
        tests++;
        if ({select_ula, data1_out, data2_out, illegal} !== {4'b0101, 32'h7, 32'h9, 1'b0}) begin
            fails++;
            $display("FAIL bltu: got sel=%b d1=%h d2=%h ill=%b want 0101 7 9 0",
                     select_ula, data1_out, data2_out, illegal);
        end
        present(7'b0110111, 3'b000, 7'b0000000, 32'h7, 32'h9, 32'hABCDE000, 32'h0);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({select_ula, data1_out, data2_out} !== {4'b0001, 32'h0, 32'hABCDE000}) begin
            fails++;
            $display("FAIL lui: got sel=%b d1=%h d2=%h want 0001 0 abcde000", select_ula, data1_out, data2_out);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        present(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'h0, 32'h0);
        tick();
        present(7'b0110011, 3'b110, 7'b0000000, 32'd2, 32'd2, 32'h0, 32'h0);
        tick();
        present(7'b0110011, 3'b100, 7'b0000000, 32'hBAD, 32'hBAD, 32'h0, 32'h0);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++; $display("FAIL flush_empty: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_dropped_input: got ov=%b d1=%h want ov 0", out_valid, data1_out);
        end
    endtask

    task automatic test_illegal();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        present(7'b1111111, 3'b000, 7'b0000000, 32'h11, 32'h22, 32'h33, 32'h44);
        tick();
        tick();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, illegal, select_ula, data1_out, data2_out} !== {1'b1, 1'b1, 4'b0000, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL illegal_opcode: got ov=%b ill=%b sel=%b d1=%h d2=%h want 1 1 0000 0 0",
                     out_valid, illegal, select_ula, data1_out, data2_out);
        end
        out_ready = 1'b1;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL illegal_drained: got ov=%b want 0", out_valid);
        end
`ifdef ULA_CTRL_STATS_EN
        tests++;
        if (illegal_count !== 16'd2) begin
            fails++; $display("FAIL illegal_count: got %0d want 2", illegal_count);
        end
`endif
        // a disallowed branch funct3 is illegal too
        present(7'b1100011, 3'b010, 7'b0000000, 32'h11, 32'h22, 32'h0, 32'h0);
        out_ready = 1'b0;
        tick();
        tests++;
        if ({illegal, select_ula, data1_out} !== {1'b1, 4'b0000, 32'h0}) begin
            fails++;
            $display("FAIL branch_f3_illegal: got ill=%b sel=%b d1=%h want 1 0000 0", illegal, select_ula, data1_out);
        end
        present(7'b0110011, 3'b100, 7'b0000000, 32'h11, 32'h22, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, select_ula, data1_out, data2_out, illegal} !== 71'd0) begin
            fails++;
            $display("FAIL midstream_reset: got ov=%b ir=%b sel=%b d1=%h d2=%h ill=%b want all 0",
                     out_valid, in_ready, select_ula, data1_out, data2_out, illegal);
        end
`ifdef ULA_CTRL_STATS_EN
        tests++;
        if (illegal_count !== 16'd0) begin
            fails++; $display("FAIL midstream_reset_count: got %0d want 0", illegal_count);
        end
`endif
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_sra_imm();
        test_back_to_back();
        test_auipc_jal();
        test_branch_lui();
        test_flush();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
